irq_eoi_ctrl: RTL and testbench

- Interrupt front-end inside SOC, directly downstream of the 16 IRQ input pads and directly upstream of the 16 EOI output pads.
- Synchronises the asynchronous pad-level irq lines and latches them as pending per line (edge or level mode).
- Presents the highest-priority unmasked pending line to the core with a valid/ack handshake and tracks it as in-service.
- On a core "done" command, pulses the matching eoi line for a fixed number of cycles.

---
 rtl/irq_eoi_ctrl.sv | 95 +++++++++
 tb/tb_irq_eoi_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_eoi_ctrl.sv
// irq_eoi_ctrl: synchronises pad irqs, latches pending, presents the lowest-index eligible line
// with valid/ack, tracks in-service lines and pulses the matching EOI line on completion.
module irq_eoi_ctrl #(
    parameter int N_IRQ       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EOI_PULSE   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IRQ-1:0]         irq_i,
    input  logic [N_IRQ-1:0]         mask_i,
    input  logic [N_IRQ-1:0]         edge_mode_i,
    output logic                     int_valid_o,
    output logic [$clog2(N_IRQ)-1:0] int_id_o,
    input  logic                     int_ack_i,
    input  logic                     done_valid_i,
    input  logic [$clog2(N_IRQ)-1:0] done_id_i,
    output logic                     done_ready_o,
    output logic [N_IRQ-1:0]         eoi_o,
    output logic [N_IRQ-1:0]         in_service_o,
    output logic                     spurious_o
);
    localparam int IW = $clog2(N_IRQ);
    localparam int CW = $clog2(EOI_PULSE + 1);
    localparam logic [N_IRQ-1:0] ONE = 1;

    logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [N_IRQ-1:0] r_s_d, r_pend, r_insvc, r_eoi;
    logic             r_valid, r_spur;
    logic [IW-1:0]    r_id;
    logic [CW-1:0]    r_cnt;

    logic [N_IRQ-1:0] w_s, w_ack_oh, w_set, w_elig, w_done_oh;
    logic [IW-1:0]    w_win;
    logic             w_ack, w_done_acc, w_done_hit;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_ack      = int_ack_i & r_valid;
    assign w_ack_oh   = w_ack ? ONE << r_id : '0;
    // the line being acked counts as in service already, so level mode cannot re-pend it on the ack edge
    assign w_set      = (edge_mode_i & w_s & ~r_s_d) | (~edge_mode_i & w_s & ~(r_insvc | w_ack_oh));
    assign w_elig     = r_pend & ~mask_i & ~r_insvc;
    assign w_done_acc = done_valid_i & done_ready_o;
    assign w_done_hit = w_done_acc & r_insvc[done_id_i];
    assign w_done_oh  = w_done_hit ? ONE << done_id_i : '0;

    assign done_ready_o = r_cnt == '0;
    assign int_valid_o  = r_valid;
    assign int_id_o     = r_id;
    assign eoi_o        = r_eoi;
    assign in_service_o = r_insvc;
    assign spurious_o   = r_spur;

    always_comb begin
        w_win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (w_elig[i]) w_win = IW'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            r_s_d <= '0;
        end else begin
            r_sync[0] <= irq_i;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_s_d <= w_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_insvc <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_spur  <= 1'b0;
            r_cnt   <= '0;
            r_eoi   <= '0;
        end else begin
            r_pend  <= (r_pend & ~w_ack_oh) | w_set;
            r_insvc <= (r_insvc | w_ack_oh) & ~w_done_oh;
            r_valid <= r_valid ? ~int_ack_i : |w_elig;
            if (!r_valid && |w_elig) r_id <= w_win;
            r_spur  <= w_done_acc & ~w_done_hit;
            if (w_done_hit) begin
                r_cnt <= CW'(EOI_PULSE);
                r_eoi <= w_done_oh;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) r_eoi <= '0;
            end
        end
    end
endmodule

// File: tb/tb_irq_eoi_ctrl.sv
// tb_irq_eoi_ctrl: priority table, directed corner sequences and a randomized run
// against a cycle-level behavioural model of the interrupt front-end.
module tb_irq_eoi_ctrl;
    localparam int EOI = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] irq_i = '0, mask_i = '0, edge_mode_i = '0;
    logic        int_valid_o, int_ack_i = 1'b0, done_valid_i = 1'b0, done_ready_o, spurious_o;
    logic [3:0]  int_id_o, done_id_i = '0;
    logic [15:0] eoi_o, in_service_o;

    int checks = 0, failures = 0;

    irq_eoi_ctrl dut (
        .clk(clk), .rst(rst), .irq_i(irq_i), .mask_i(mask_i), .edge_mode_i(edge_mode_i),
        .int_valid_o(int_valid_o), .int_id_o(int_id_o), .int_ack_i(int_ack_i),
        .done_valid_i(done_valid_i), .done_id_i(done_id_i), .done_ready_o(done_ready_o),
        .eoi_o(eoi_o), .in_service_o(in_service_o), .spurious_o(spurious_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] irq, mask, edge_m;
        logic        exp_v;
        logic [3:0]  exp_id;
    } vec_t;
    vec_t vt [8];

    // model state: pad samples (index 0 newest), pending, in-service, presentation, eoi pulse
    logic [15:0] m_hist [3];
    logic [15:0] m_pend, m_insvc;
    logic        m_valid, m_spur;
    int          m_id, m_line, m_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        irq_i = '0; mask_i = '0; edge_mode_i = '0;
        int_ack_i = 1'b0; done_valid_i = 1'b0; done_id_i = '0;
        step(2);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) m_hist[k] = '0;
        m_pend = '0; m_insvc = '0; m_valid = 1'b0; m_spur = 1'b0;
        m_id = 0; m_line = 0; m_left = 0;
    endtask

    // advances the model by one clock edge using the inputs that will be sampled at that edge
    task automatic model_step();
        logic [15:0] s, sd, np, ni;
        int acked, win;
        s = m_hist[1];
        sd = m_hist[2];
        acked = (m_valid && int_ack_i) ? m_id : -1;
        np = m_pend;
        ni = m_insvc;
        win = -1;
        for (int i = 15; i >= 0; i--)
            if (m_pend[i] && !mask_i[i] && !m_insvc[i]) win = i;
        for (int i = 0; i < 16; i++) begin
            logic set_i;
            set_i = edge_mode_i[i] ? (s[i] && !sd[i]) : (s[i] && !m_insvc[i] && i != acked);
            np[i] = set_i || (m_pend[i] && i != acked);
            if (i == acked) ni[i] = 1'b1;
        end
        m_spur = 1'b0;
        if (done_valid_i && m_left == 0) begin
            if (m_insvc[done_id_i]) begin
                ni[done_id_i] = 1'b0;
                m_line = int'(done_id_i);
                m_left = EOI;
            end else m_spur = 1'b1;
        end else if (m_left > 0) m_left--;
        if (m_valid) begin
            if (int_ack_i) m_valid = 1'b0;
        end else if (win >= 0) begin
            m_valid = 1'b1;
            m_id = win;
        end
        m_pend = np;
        m_insvc = ni;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = irq_i;
    endtask

    initial begin
        logic [15:0] acc_eoi;
        logic        acc_v;
        vt[0] = '{16'h0020, 16'h0000, 16'hFFFF, 1'b1, 4'd5};
        vt[1] = '{16'h8201, 16'h0000, 16'hFFFF, 1'b1, 4'd0};
        vt[2] = '{16'h8200, 16'h0200, 16'hFFFF, 1'b1, 4'd15};
        vt[3] = '{16'h00F0, 16'h0030, 16'h0000, 1'b1, 4'd6};
        vt[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 4'd0};
        vt[5] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b0, 4'd0};
        vt[6] = '{16'hC000, 16'h4000, 16'h0000, 1'b1, 4'd15};
        vt[7] = '{16'h0006, 16'h0000, 16'h0002, 1'b1, 4'd1};

        step(1);
        chk("reset_valid", int_valid_o, 0);
        chk("reset_eoi", eoi_o, 0);
        chk("reset_insvc", in_service_o, 0);
        chk("reset_ready", done_ready_o, 1);
        chk("reset_spur", spurious_o, 0);

        for (int k = 0; k < 8; k++) begin
            do_reset();
            irq_i = vt[k].irq; mask_i = vt[k].mask; edge_mode_i = vt[k].edge_m;
            step(4);
            chk($sformatf("tbl%0d_valid", k), int_valid_o, vt[k].exp_v);
            chk($sformatf("tbl%0d_id", k), int_id_o, vt[k].exp_id);
        end

        // edge basic: exact latency, ack, 4-cycle EOI pulse
        do_reset();
        edge_mode_i = 16'hFFFF; irq_i = 16'h0020;
        step(3);
        chk("edge_early_valid", int_valid_o, 0);
        step(1);
        chk("edge_valid", int_valid_o, 1);
        chk("edge_id", int_id_o, 5);
        int_ack_i = 1'b1; step(1); int_ack_i = 1'b0;
        chk("edge_ack_valid", int_valid_o, 0);
        chk("edge_insvc", in_service_o, 16'h0020);
        done_valid_i = 1'b1; done_id_i = 4'd5; step(1); done_valid_i = 1'b0;
        for (int c = 0; c < EOI; c++) begin
            chk($sformatf("edge_eoi_c%0d", c), eoi_o, 16'h0020);
            chk($sformatf("edge_ready_c%0d", c), done_ready_o, 0);
            step(1);
        end
        chk("edge_eoi_end", eoi_o, 0);
        chk("edge_ready_end", done_ready_o, 1);
        chk("edge_insvc_end", in_service_o, 0);

        // priority / stability
        do_reset();
        edge_mode_i = 16'hFFFF; irq_i = 16'h0200;
        step(4);
        chk("prio_id9", int_id_o, 9);
        irq_i = 16'h0204;
        for (int c = 0; c < 5; c++) begin
            step(1);
            chk("prio_hold_id", int_id_o, 9);
            chk("prio_hold_valid", int_valid_o, 1);
        end
        int_ack_i = 1'b1; step(1); int_ack_i = 1'b0;
        chk("prio_gap", int_valid_o, 0);
        step(1);
        chk("prio_next_valid", int_valid_o, 1);
        chk("prio_next_id", int_id_o, 2);

        // mask then unmask
        do_reset();
        edge_mode_i = 16'hFFFF; mask_i = 16'h0008; irq_i = 16'h0008;
        step(6);
        chk("mask_novalid", int_valid_o, 0);
        mask_i = '0;
        step(1);
        chk("unmask_valid", int_valid_o, 1);
        chk("unmask_id", int_id_o, 3);

        // level re-trigger after EOI
        do_reset();
        irq_i = 16'h0001;
        step(4);
        chk("lvl_id0", int_id_o, 0);
        chk("lvl_valid", int_valid_o, 1);
        int_ack_i = 1'b1; step(1); int_ack_i = 1'b0;
        chk("lvl_insvc", in_service_o, 16'h0001);
        step(3);
        chk("lvl_no_represent", int_valid_o, 0);
        done_valid_i = 1'b1; done_id_i = 4'd0; step(1); done_valid_i = 1'b0;
        chk("lvl_eoi", eoi_o, 16'h0001);
        chk("lvl_insvc_clr", in_service_o, 0);
        chk("lvl_v_p0", int_valid_o, 0);
        step(1);
        chk("lvl_v_p1", int_valid_o, 0);
        step(1);
        chk("lvl_re_valid", int_valid_o, 1);
        chk("lvl_re_id", int_id_o, 0);

        // spurious done and backpressure
        do_reset();
        done_valid_i = 1'b1; done_id_i = 4'd7; step(1); done_valid_i = 1'b0;
        chk("spur_pulse", spurious_o, 1);
        chk("spur_eoi", eoi_o, 0);
        chk("spur_ready", done_ready_o, 1);
        step(1);
        chk("spur_one_cycle", spurious_o, 0);
        edge_mode_i = 16'hFFFF; irq_i = 16'h0012;
        step(4);
        chk("bp_id1", int_id_o, 1);
        int_ack_i = 1'b1; step(1); int_ack_i = 1'b0;
        step(1);
        chk("bp_id4", int_id_o, 4);
        int_ack_i = 1'b1; step(1); int_ack_i = 1'b0;
        chk("bp_insvc", in_service_o, 16'h0012);
        done_valid_i = 1'b1; done_id_i = 4'd1; step(1);
        done_id_i = 4'd4;
        for (int c = 0; c < EOI; c++) begin
            chk("bp_eoi1", eoi_o, 16'h0002);
            chk("bp_ready", done_ready_o, 0);
            chk("bp_insvc4", in_service_o, 16'h0010);
            step(1);
        end
        chk("bp_eoi_gap", eoi_o, 0);
        chk("bp_ready_back", done_ready_o, 1);
        step(1);
        done_valid_i = 1'b0;
        chk("bp_eoi4", eoi_o, 16'h0010);
        chk("bp_insvc_done", in_service_o, 0);

        // reset in the middle of a pulse with three lines pending
        do_reset();
        edge_mode_i = 16'hFFFF; mask_i = 16'h1C00; irq_i = 16'h1C40;
        step(4);
        chk("rst_id6", int_id_o, 6);
        int_ack_i = 1'b1; step(1); int_ack_i = 1'b0;
        done_valid_i = 1'b1; done_id_i = 4'd6; step(1); done_valid_i = 1'b0;
        step(1);
        chk("rst_pre_eoi", eoi_o, 16'h0040);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_eoi", eoi_o, 0);
        chk("rst_async_insvc", in_service_o, 0);
        chk("rst_async_valid", int_valid_o, 0);
        chk("rst_async_ready", done_ready_o, 1);
        irq_i = '0; mask_i = '0;
        step(2);
        rst = 1'b0;
        acc_eoi = '0; acc_v = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(1);
            acc_eoi |= eoi_o;
            acc_v |= int_valid_o;
        end
        chk("rst_after_eoi", acc_eoi, 0);
        chk("rst_after_valid", acc_v, 0);
        chk("rst_after_ready", done_ready_o, 1);

        // randomized run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) edge_mode_i = 16'($urandom);
            if (c % 64 == 0) mask_i = 16'($urandom & $urandom);
            irq_i ^= 16'($urandom & $urandom & $urandom);
            int_ack_i = ($urandom % 3) == 0;
            done_valid_i = ($urandom % 4) == 0;
            done_id_i = 4'($urandom);
            if (m_insvc != 0 && ($urandom % 4) != 0) begin
                int st;
                st = int'($urandom % 16);
                for (int j = 0; j < 16; j++)
                    if (m_insvc[(st + j) % 16]) done_id_i = 4'((st + j) % 16);
            end
            model_step();
            step(1);
            chk("rnd_valid", int_valid_o, m_valid);
            if (m_valid) chk("rnd_id", int_id_o, m_id);
            chk("rnd_insvc", in_service_o, m_insvc);
            chk("rnd_eoi", eoi_o, m_left > 0 ? 16'd1 << m_line : 16'd0);
            chk("rnd_ready", done_ready_o, m_left == 0);
            chk("rnd_spur", spurious_o, m_spur);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
